// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register.
// Emits one registered window per interior pixel, with centre coordinates
// and an end-of-frame pulse.
module sobel_window_gen #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned CW         = $clog2(IMG_WIDTH),
    parameter int unsigned RW         = $clog2(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    pixel_in,
    input  logic          pixel_valid,
    input  logic          frame_start,
    output logic [7:0]    windowBuffer [0:8],
    output logic          start_calculations,
    output logic [CW-1:0] center_col,
    output logic [RW-1:0] center_row,
    output logic          frame_done
);

    localparam int unsigned PW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] eff_col;
    logic [RW-1:0] eff_row;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;
    logic          line_end_c;
    logic          frame_end_c;
    logic          win_valid_c;
    logic          frame_last_c;

    logic [PW-1:0] lb0 [0:IMG_WIDTH-1];
    logic [PW-1:0] lb1 [0:IMG_WIDTH-1];
    logic [PW-1:0] lb0_rd;
    logic [PW-1:0] lb1_rd;

    logic [PW-1:0] sh     [0:8];
    logic [PW-1:0] sh_nxt [0:8];

    // Position of the pixel being accepted; frame_start forces it to (0,0)
    always_comb begin
        eff_col     = frame_start ? '0 : col;
        eff_row     = frame_start ? '0 : row;
        line_end_c  = (eff_col == CW'(IMG_WIDTH - 1));
        frame_end_c = line_end_c && (eff_row == RW'(IMG_HEIGHT - 1));
        col_nxt     = line_end_c ? '0 : eff_col + CW'(1);
        if (frame_end_c) begin
            row_nxt = '0;
        end else if (line_end_c) begin
            row_nxt = eff_row + RW'(1);
        end else begin
            row_nxt = eff_row;
        end
        lb0_rd = lb0[eff_col];
        lb1_rd = lb1[eff_col];
    end

    // Line buffers: read-before-write, LB1 cascades into LB0 (not reset)
    always_ff @(posedge clk) begin
        if (pixel_valid && !reset) begin
            lb0[eff_col] <= lb1_rd;
            lb1[eff_col] <= pixel_in;
        end
    end

    // Column/row counters and FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            col   <= '0;
            row   <= '0;
            state <= IDLE;
        end else if (pixel_valid) begin
            col   <= col_nxt;
            row   <= row_nxt;
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = FILL;
        end else begin
            case (state)
                IDLE:    state_nxt = FILL;
                FILL:    if (eff_row == RW'(2) && eff_col == '0) state_nxt = ACTIVE;
                ACTIVE:  if (frame_end_c) state_nxt = FILL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Window validity: interior positions only, never straddling a line wrap
    always_comb begin
        win_valid_c  = 1'b0;
        frame_last_c = 1'b0;
        if (pixel_valid && !frame_start && state == ACTIVE &&
            eff_row >= RW'(2) && eff_col >= CW'(2)) begin
            win_valid_c  = 1'b1;
            frame_last_c = frame_end_c;
        end
    end

    // Shift every window row left; new right column is {LB0, LB1, pixel}
    always_comb begin
        sh_nxt[0] = sh[1];
        sh_nxt[1] = sh[2];
        sh_nxt[2] = lb0_rd;
        sh_nxt[3] = sh[4];
        sh_nxt[4] = sh[5];
        sh_nxt[5] = lb1_rd;
        sh_nxt[6] = sh[7];
        sh_nxt[7] = sh[8];
        sh_nxt[8] = pixel_in;
    end

    // Shift register and registered outputs; window/centre hold between windows
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                sh[i]           <= '0;
                windowBuffer[i] <= '0;
            end
            start_calculations <= 1'b0;
            frame_done         <= 1'b0;
            center_col         <= '0;
            center_row         <= '0;
        end else begin
            start_calculations <= win_valid_c;
            frame_done         <= frame_last_c;
            if (pixel_valid) begin
                for (int i = 0; i < 9; i++) sh[i] <= sh_nxt[i];
            end
            if (win_valid_c) begin
                for (int i = 0; i < 9; i++) windowBuffer[i] <= sh_nxt[i];
                center_col <= eff_col - CW'(1);
                center_row <= eff_row - RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 image.
module tb_sobel_window_gen;

    localparam int unsigned W  = 5;
    localparam int unsigned H  = 4;
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned RW = $clog2(H);

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    pixel_in;
    logic          pixel_valid;
    logic          frame_start;
    logic [7:0]    windowBuffer [0:8];
    logic          start_calculations;
    logic [CW-1:0] center_col;
    logic [RW-1:0] center_row;
    logic          frame_done;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [7:0]    exp_win [0:8];
    int            exp_cr;
    int            exp_cc;
    int            strobes;
    int            dones;

    sobel_window_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .CW        (CW),
        .RW        (RW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pixel_in          (pixel_in),
        .pixel_valid       (pixel_valid),
        .frame_start       (frame_start),
        .windowBuffer      (windowBuffer),
        .start_calculations(start_calculations),
        .center_col        (center_col),
        .center_row        (center_row),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] pv(input int mode, input logic [7:0] base, input int r, input int c);
        if (mode == 1) return 8'(c * 10);
        return 8'(int'(base) + r * 16 + c);
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic [7:0] pix, input logic v, input logic fs, input logic rst);
        pixel_in    = pix;
        pixel_valid = v;
        frame_start = fs;
        reset       = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input logic es, input logic ed);
        chk("start_calculations", 32'(start_calculations), 32'(es));
        chk("frame_done", 32'(frame_done), 32'(ed));
        chk("center_row", 32'(center_row), 32'(exp_cr));
        chk("center_col", 32'(center_col), 32'(exp_cc));
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("window[%0d]", k), 32'(windowBuffer[k]), 32'(exp_win[k]));
        end
    endtask

    // Stream npix raster pixels; optionally two stalled cycles after each pixel
    task automatic stream(input int mode, input logic [7:0] base, input logic fs_first,
                          input int npix, input logic stall, output int nstr, output int ndone);
        nstr  = 0;
        ndone = 0;
        for (int p = 0; p < npix; p++) begin
            int   r;
            int   c;
            logic es;
            logic ed;
            int   gx;
            r  = (p / int'(W)) % int'(H);
            c  = p % int'(W);
            step(pv(mode, base, r, c), 1'b1, (p == 0) && fs_first, 1'b0);
            es = (r >= 2) && (c >= 2);
            ed = es && (r == int'(H) - 1) && (c == int'(W) - 1);
            if (es) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_win[3*i+j] = pv(mode, base, r - 2 + i, c - 2 + j);
                exp_cr = r - 1;
                exp_cc = c - 1;
                nstr++;
            end
            if (ed) ndone++;
            check_outputs(es, ed);
            if (es && mode == 1) begin
                gx = (int'(windowBuffer[2]) + 2 * int'(windowBuffer[5]) + int'(windowBuffer[8]))
                   - (int'(windowBuffer[0]) + 2 * int'(windowBuffer[3]) + int'(windowBuffer[6]));
                chk("gx", 32'(gx), 32'd80);
            end
            if (stall) begin
                repeat (2) begin
                    step(8'hEE, 1'b0, 1'b1, 1'b0);
                    check_outputs(1'b0, 1'b0);
                end
            end
        end
    endtask

    task automatic clear_expected();
        for (int k = 0; k < 9; k++) exp_win[k] = 8'h00;
        exp_cr = 0;
        exp_cc = 0;
    endtask

    initial begin
        clear_expected();

        // Reset state
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b1, 1'b0, 1'b1);
        check_outputs(1'b0, 1'b0);

        // Full frame with frame_start
        stream(0, 8'h00, 1'b1, 20, 1'b0, strobes, dones);
        chk("frame1_strobes", 32'(strobes), 32'd6);
        chk("frame1_dones", 32'(dones), 32'd1);

        // Back-to-back frame without frame_start
        stream(0, 8'h80, 1'b0, 20, 1'b0, strobes, dones);
        chk("frame2_strobes", 32'(strobes), 32'd6);
        chk("frame2_dones", 32'(dones), 32'd1);

        // Stalled frame: valid pattern 1,0,0 repeating
        stream(0, 8'h40, 1'b1, 20, 1'b1, strobes, dones);
        chk("stall_strobes", 32'(strobes), 32'd6);
        chk("stall_dones", 32'(dones), 32'd1);

        // Abort at pixel (2,3) by frame_start
        stream(0, 8'h00, 1'b1, 13, 1'b0, strobes, dones);
        chk("abort_strobes", 32'(strobes), 32'd1);
        chk("abort_dones", 32'(dones), 32'd0);
        stream(0, 8'h80, 1'b1, 20, 1'b0, strobes, dones);
        chk("restart_strobes", 32'(strobes), 32'd6);
        chk("restart_dones", 32'(dones), 32'd1);

        // Reset pulsed at pixel (3,1)
        stream(0, 8'h40, 1'b1, 16, 1'b0, strobes, dones);
        chk("pre_reset_strobes", 32'(strobes), 32'd3);
        step(pv(0, 8'h40, 3, 1), 1'b1, 1'b0, 1'b1);
        clear_expected();
        check_outputs(1'b0, 1'b0);
        stream(0, 8'h00, 1'b0, 20, 1'b0, strobes, dones);
        chk("post_reset_strobes", 32'(strobes), 32'd6);
        chk("post_reset_dones", 32'(dones), 32'd1);

        // Horizontal ramp: constant horizontal gradient
        stream(1, 8'h00, 1'b1, 20, 1'b0, strobes, dones);
        chk("ramp_strobes", 32'(strobes), 32'd6);

        step(8'h00, 1'b0, 1'b0, 1'b0);
        check_outputs(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator for the Sobel edge-detection pipeline. It accepts 8-bit grayscale pixels in raster order, one per `clk` when `pixel_valid` is high, and keeps two full line buffers plus a 3x3 shift register. For every interior pixel position it presents a complete 9-pixel neighbourhood on `windowBuffer` with a one-cycle `start_calculations` strobe. It is the producer side of the `windowBuffer`/`start_calculations` interface consumed by the horizontal and vertical gradient blocks.

## Interface
- `IMG_WIDTH`, 640: pixels per line; must be ≥ 3.
- `IMG_HEIGHT`, 480: lines per frame; must be ≥ 3.
- `CW`, $clog2(IMG_WIDTH): column counter width (derived).
- `RW`, $clog2(IMG_HEIGHT): row counter width (derived).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pixel_in`  in  8  grayscale pixel, unsigned.
- `pixel_valid`  in  1  `pixel_in` is accepted this cycle. No backpressure: the block is always ready.
- `frame_start`  in  1  qualified by `pixel_valid`. Marks the accepted pixel as (row 0, col 0).
- `windowBuffer`  out  8 x [0:8]  3x3 window, row-major. [0..2] is the oldest line, [3..5] the middle line, [6..8] the newest line. Within each line the lowest index is the leftmost (oldest) column.
- `start_calculations`  out  1  one-cycle strobe: `windowBuffer` holds a new valid window.
- `center_col`  out  CW  column of the window's centre pixel.
- `center_row`  out  RW  row of the window's centre pixel.
- `frame_done`  out  1  one-cycle pulse coincident with the last window of a frame.

## Operation
- Counters `col` and `row` give the position of the pixel being accepted.
  - Each accepted pixel increments `col`.
  - At `col = IMG_WIDTH-1`, `col` wraps to 0 and `row` increments.
  - At (`IMG_HEIGHT-1`, `IMG_WIDTH-1`), both counters wrap to 0.
- Line buffers: LB1 holds the previous line and LB0 holds the line before that, each `IMG_WIDTH` x 8.
  - On an accepted pixel at column c, read LB0[c] and LB1[c].
  - Write LB0[c] ← LB1[c] and LB1[c] ← `pixel_in`.
  - Read-before-write applies at the same address.
- Window shift: on an accepted pixel, each row of the 3x3 register shifts left by one column. The new rightmost column is {LB0[c], LB1[c], `pixel_in`}, placed top to bottom.
- A window is valid when the accepted pixel has row ≥ 2 and col ≥ 2.
  - This gives no border padding: each frame yields (IMG_HEIGHT-2)·(IMG_WIDTH-2) windows.
  - Gating on col ≥ 2 suppresses windows that straddle a line wrap.
- FSM states:
  - IDLE: after reset. The first accepted pixel goes to FILL.
  - FILL: rows 0–1 are being loaded; no windows are produced. Goes to ACTIVE when the pixel at (2,0) is accepted.
  - ACTIVE: windows are emitted per the validity rule. Goes to FILL when the last pixel of the frame is accepted.
- `frame_start` with `pixel_valid` in any state:
  - The pixel is forced to (0,0), the counters restart from it, and the FSM goes to FILL.
  - Any partial frame is abandoned with no `frame_done`.
  - Stale line-buffer contents are not cleared; the row gating makes them unobservable.
- Without `frame_start`, pixels following a frame's last pixel are treated as a new frame (continuous streaming).
- Arithmetic: pixels are passed through unmodified. The block does no arithmetic beyond the counters.

## Timing
- Reset values: `windowBuffer` all 0x00, `start_calculations`=0, `frame_done`=0, `center_col`=0, `center_row`=0, counters 0, FSM=IDLE. Line-buffer RAM is not reset.
- Latency: the window completed by the pixel accepted in cycle N appears registered in cycle N+1.
  - In that cycle `start_calculations`=1, with `center_col`=c-1 and `center_row`=r-1.
- `windowBuffer`, `center_col` and `center_row` hold their values until the next valid window; they do not update on non-window pixels.
- `pixel_valid`=0 freezes all state, and `start_calculations` is 0 in the following cycle.
- Throughput: one window per cycle during ACTIVE with `pixel_valid` continuously high.
- `frame_done` = 1 in the same cycle as the strobe for the window centred at (IMG_HEIGHT-2, IMG_WIDTH-2).
- `reset` mid-frame takes priority over `pixel_valid`. It returns the block to reset values next cycle, and a pending strobe is dropped.

## Test plan
Directed scenarios use IMG_WIDTH=5, IMG_HEIGHT=4, and `pixel_in` = row·16 + col unless stated.

- **Full frame, continuous valid, `frame_start` on first pixel.**
  - Exactly 6 strobes.
  - First strobe is one cycle after pixel (2,2) is accepted, with `windowBuffer` = {00,01,02,10,11,12,20,21,22} and centre (1,1).
  - Last strobe has centre (2,3), `windowBuffer` = {12,13,14,22,23,24,32,33,34}, and `frame_done`=1.
- **Same frame with `pixel_valid` toggled 1,0,0,1,…**
  - Identical window sequence and centres.
  - No strobe follows a stalled cycle.
  - Outputs stay stable across stalls.
- **Two back-to-back frames, no second `frame_start`.**
  - 12 strobes in total.
  - The second frame's first window is centre (1,1) with values from frame 2 only.
- **`frame_start` asserted at pixel (2,3) of frame 1.**
  - No `frame_done` for the aborted frame.
  - The next strobe occurs only after the new frame's pixel (2,2) is accepted.
- **`reset` pulsed at pixel (3,1), then a new frame is streamed.**
  - All outputs are 0 the next cycle.
  - The new frame produces exactly 6 correct windows.
- **Gradient check with a downstream gradient block and `pixel_in` = col·10.**
  - Every window has gx = 80.
